// File: rtl/seg_scan_driver_if.sv
// Handshake and display bus between the time/alarm counters and the seven-segment scan driver.
// Master drives the binary fields and controls; slave returns status and the display pins.
interface seg_scan_driver_if #(
  parameter int unsigned NUM_FIELDS = 2,
  parameter int unsigned FIELD_W    = 6
);
  logic [NUM_FIELDS*FIELD_W-1:0] bin_in;
  logic                          load;
  logic [NUM_FIELDS-1:0]         blink_en;
  logic                          lz_blank;
  logic                          busy;
  logic                          done;
  logic [6:0]                    seg;
  logic [2*NUM_FIELDS-1:0]       dig_sel;

  modport master (
    output bin_in, load, blink_en, lz_blank,
    input  busy, done, seg, dig_sel
  );

  modport slave (
    input  bin_in, load, blink_en, lz_blank,
    output busy, done, seg, dig_sel
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Converts packed binary fields to BCD with a shift-add-3 engine and drives a time-multiplexed
// seven-segment display with per-field blink and optional leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned NUM_FIELDS = 2,
  parameter int unsigned FIELD_W    = 6,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 500000
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_driver_if.slave  io_bus
);
  localparam int unsigned NUM_DIGITS = 2 * NUM_FIELDS;
  localparam int unsigned BIN_W      = NUM_FIELDS * FIELD_W;
  localparam int unsigned FIDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned BIT_W      = $clog2(FIELD_W);
  localparam int unsigned DIDX_W     = $clog2(NUM_DIGITS);
  localparam int unsigned SCAN_W     = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W    = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_ZERO  = 7'b1111110;

  function automatic logic [6:0] f_encode(input logic [3:0] d);
    case (d)
      4'd0:    f_encode = 7'b1111110;
      4'd1:    f_encode = 7'b0110000;
      4'd2:    f_encode = 7'b1101101;
      4'd3:    f_encode = 7'b1111001;
      4'd4:    f_encode = 7'b0110011;
      4'd5:    f_encode = 7'b1011011;
      4'd6:    f_encode = 7'b1011111;
      4'd7:    f_encode = 7'b1110000;
      4'd8:    f_encode = 7'b1111111;
      4'd9:    f_encode = 7'b1111011;
      default: f_encode = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e                         r_state, w_state_next;
  logic [BIN_W-1:0]               r_shadow;
  logic [7:0]                     r_bcd;
  logic [BIT_W-1:0]               r_bit;
  logic [FIDX_W-1:0]              r_field;
  logic [NUM_DIGITS-1:0][6:0]     r_stage, r_disp;
  logic                           r_done;
  logic [SCAN_W-1:0]              r_presc;
  logic [DIDX_W-1:0]              r_idx;
  logic [BLINK_W-1:0]             r_blink_cnt;
  logic                           r_phase;
  logic [6:0]                     r_seg;
  logic [NUM_DIGITS-1:0]          r_dig_sel;

  logic                           w_busy, w_accept, w_shift, w_commit;
  logic [BIN_W-1:0]               w_shifted;
  logic [FIELD_W-1:0]             w_cur_field, w_aligned;
  logic                           w_in_bit, w_last_bit, w_last_field, w_range_err;
  logic [7:0]                     w_adj, w_bcd_next;
  logic [6:0]                     w_digit_code, w_seg_pick;
  logic                           w_blink_here;

  // Conversion datapath: current field's next serial bit and the add-3 adjusted BCD pair.
  always_comb begin
    w_shifted    = r_shadow >> (r_field * FIELD_W);
    w_cur_field  = w_shifted[FIELD_W-1:0];
    w_aligned    = w_cur_field << r_bit;
    w_in_bit     = w_aligned[FIELD_W-1];
    w_adj[3:0]   = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    w_adj[7:4]   = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
    w_bcd_next   = {w_adj[6:0], w_in_bit};
    w_last_bit   = (r_bit == BIT_W'(FIELD_W - 1));
    w_last_field = (r_field == FIDX_W'(NUM_FIELDS - 1));
    w_range_err  = ({{(16 - FIELD_W){1'b0}}, w_cur_field} > 16'd99);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (io_bus.load) w_state_next = StConv;
      StConv:   if (w_last_bit && w_last_field) w_state_next = StCommit;
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != StIdle);
    w_accept = (r_state == StIdle) && io_bus.load;
    w_shift  = (r_state == StConv);
    w_commit = (r_state == StCommit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_bcd    <= '0;
      r_bit    <= '0;
      r_field  <= '0;
      r_stage  <= {NUM_DIGITS{SEG_BLANK}};
      r_disp   <= {NUM_DIGITS{SEG_BLANK}};
      r_done   <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_shadow <= io_bus.bin_in;
        r_bcd    <= '0;
        r_bit    <= '0;
        r_field  <= '0;
      end
      if (w_shift) begin
        if (w_last_bit) begin
          r_bcd   <= '0;
          r_bit   <= '0;
          r_field <= r_field + FIDX_W'(1);
          for (int k = 0; k < NUM_FIELDS; k++) begin
            if (r_field == FIDX_W'(k)) begin
              r_stage[2*k]   <= w_range_err ? SEG_DASH : f_encode(w_bcd_next[3:0]);
              r_stage[2*k+1] <= w_range_err ? SEG_DASH : f_encode(w_bcd_next[7:4]);
            end
          end
        end else begin
          r_bcd <= w_bcd_next;
          r_bit <= r_bit + BIT_W'(1);
        end
      end
      if (w_commit) r_disp <= r_stage;
    end
  end

  // Segment selection for the digit currently indexed; blink overrides leading-zero handling.
  always_comb begin
    w_digit_code = r_disp[r_idx];
    w_blink_here = 1'b0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (r_idx == DIDX_W'(2*k) || r_idx == DIDX_W'(2*k+1)) w_blink_here = io_bus.blink_en[k];
    end
    w_seg_pick = w_digit_code;
    if (io_bus.lz_blank && r_idx[0] && (w_digit_code == SEG_ZERO)) w_seg_pick = SEG_BLANK;
    if (r_phase && w_blink_here) w_seg_pick = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_seg       <= SEG_BLANK;
      r_dig_sel   <= '0;
    end else begin
      if (r_presc == SCAN_W'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == DIDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + DIDX_W'(1);
      end else begin
        r_presc <= r_presc + SCAN_W'(1);
      end
      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
      r_dig_sel <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
      r_seg     <= w_seg_pick;
    end
  end

  assign io_bus.busy    = w_busy;
  assign io_bus.done    = r_done;
  assign io_bus.seg     = r_seg;
  assign io_bus.dig_sel = r_dig_sel;
endmodule
